// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, game colours and player paddle defaults
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  localparam logic [11:0] GAME_BG_COLOR = 12'h024;
  localparam logic [11:0] PLAYER_COLOR  = 12'hfa0;

  // Paddle geometry shared with the collision logic
  localparam int PLAYER_W_DEF    = 64;
  localparam int PLAYER_H_DEF    = 16;
  localparam int PLAYER_Y_DEF    = 560;
  localparam int PLAYER_STEP_DEF = 4;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing plus 12-bit rgb bundle passed between draw stages
interface vga_if;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);

endinterface

// File: rtl/player_ctl.sv
// rtl/player_ctl.sv - frame tick detect and clamped paddle x position register
module player_ctl
  import vga_pkg::*;
#(
  parameter int STEP   = PLAYER_STEP_DEF,
  parameter int X_INIT = (HOR_PIXELS - PLAYER_W_DEF) / 2,
  parameter int X_MAX  = HOR_PIXELS - PLAYER_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [10:0] player_x
);

  localparam logic [11:0] STEP12  = 12'(STEP);
  localparam logic [11:0] X_MAX12 = 12'(X_MAX);

  logic        vblnk_d;
  logic        tick;
  logic [11:0] sum_right;
  logic [10:0] x_right;
  logic [10:0] x_left;
  logic [10:0] x_nxt;

  assign tick = vblnk & ~vblnk_d;

  // Next position: right saturates at the screen edge, left saturates at 0
  always_comb begin
    sum_right = {1'b0, player_x} + STEP12;
    x_right   = (sum_right > X_MAX12) ? X_MAX12[10:0] : sum_right[10:0];
    x_left    = ({1'b0, player_x} < STEP12) ? 11'd0 : player_x - STEP12[10:0];
    x_nxt     = player_x;
    if (btn_right && !btn_left) begin
      x_nxt = x_right;
    end else if (btn_left && !btn_right) begin
      x_nxt = x_left;
    end
  end

  // vblnk_d resets high so leaving reset inside vblank does not look like a rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d  <= 1'b1;
      player_x <= 11'(X_INIT);
    end else begin
      vblnk_d <= vblnk;
      if (tick) begin
        player_x <= x_nxt;
      end
    end
  end

endmodule

// File: rtl/draw_player.sv
// rtl/draw_player.sv - paints the player paddle over the background with one cycle latency
module draw_player
  import vga_pkg::*;
#(
  parameter int PLAYER_W = PLAYER_W_DEF,
  parameter int PLAYER_H = PLAYER_H_DEF,
  parameter int PLAYER_Y = PLAYER_Y_DEF,
  parameter int STEP     = PLAYER_STEP_DEF,
  parameter int X_INIT   = (HOR_PIXELS - PLAYER_W) / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  vga_if.in           in,
  vga_if.out          out,
  output logic [10:0] player_x
);

  localparam logic [10:0] Y_TOP = 11'(PLAYER_Y);
  localparam logic [10:0] Y_BOT = 11'(PLAYER_Y + PLAYER_H - 1);
  localparam logic [11:0] W_M1  = 12'(PLAYER_W - 1);

  logic [11:0] x_lo;
  logic [11:0] x_hi;
  logic [11:0] hcount_ext;
  logic        hit;
  logic [11:0] rgb_nxt;

  player_ctl #(
    .STEP   (STEP),
    .X_INIT (X_INIT),
    .X_MAX  (HOR_PIXELS - PLAYER_W)
  ) u_player_ctl (
    .clk       (clk),
    .rst       (rst),
    .vblnk     (in.vblnk),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .player_x  (player_x)
  );

  // Rectangle test done in 12 bits so the right edge never wraps
  always_comb begin
    x_lo       = {1'b0, player_x};
    x_hi       = x_lo + W_M1;
    hcount_ext = {1'b0, in.hcount};
    hit        = (hcount_ext >= x_lo) && (hcount_ext <= x_hi) &&
                 (in.vcount >= Y_TOP) && (in.vcount <= Y_BOT) &&
                 !in.hblnk && !in.vblnk;
    rgb_nxt    = hit ? PLAYER_COLOR : in.rgb;
  end

  // Output register stage: timing delayed one clock, rgb with paddle applied
  always_ff @(posedge clk) begin
    if (rst) begin
      out.vcount <= '0;
      out.hcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= in.vcount;
      out.hcount <= in.hcount;
      out.vsync  <= in.vsync;
      out.vblnk  <= in.vblnk;
      out.hsync  <= in.hsync;
      out.hblnk  <= in.hblnk;
      out.rgb    <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_draw_player.sv
// tb/tb_draw_player.sv - directed self-checking bench for draw_player
module tb_draw_player;

  localparam logic [11:0] EXP_COLOR = 12'hfa0;

  logic        clk;
  logic        rst;
  logic        btn_left;
  logic        btn_right;
  logic [10:0] px_a;
  logic [10:0] px_b;

  int checks = 0;
  int errors = 0;

  vga_if vin ();
  vga_if vout_a ();
  vga_if vout_b ();

  draw_player dut_a (
    .clk       (clk),
    .rst       (rst),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .in        (vin),
    .out       (vout_a),
    .player_x  (px_a)
  );

  draw_player #(.X_INIT(734)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .in        (vin),
    .out       (vout_b),
    .player_x  (px_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vin.vblnk = 1'b0;
    step();
    step();
    vin.vblnk = 1'b1;
    step();
    step();
  endtask

  task automatic pix(input int h, input int v, input logic hb, input logic vb,
                     input logic [11:0] rgb, input logic [11:0] exp, input string tag);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    step();
    check(tag, int'(vout_a.rgb), int'(exp));
  endtask

  int over_cnt;
  logic [10:0] s_hc, s_vc;
  logic        s_hs, s_vs, s_hb, s_vb;

  initial begin
    rst        = 1'b1;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    vin.vblnk  = 1'b1;
    vin.hblnk  = 1'b1;
    vin.hsync  = 1'b1;
    vin.vsync  = 1'b1;
    vin.hcount = 11'd123;
    vin.vcount = 11'd45;
    vin.rgb    = 12'hfff;
    step();
    step();
    check("rst_hcount", int'(vout_a.hcount), 0);
    check("rst_vcount", int'(vout_a.vcount), 0);
    check("rst_hsync",  int'(vout_a.hsync), 0);
    check("rst_vsync",  int'(vout_a.vsync), 0);
    check("rst_hblnk",  int'(vout_a.hblnk), 0);
    check("rst_vblnk",  int'(vout_a.vblnk), 0);
    check("rst_rgb",    int'(vout_a.rgb), 0);
    check("rst_px_a",   int'(px_a), 368);
    check("rst_px_b",   int'(px_b), 734);

    // release inside vblank with right held: no movement until next rising edge
    rst       = 1'b0;
    btn_right = 1'b1;
    repeat (3) step();
    check("no_tick_after_rst", int'(px_a), 368);

    frame();
    check("right_1_a", int'(px_a), 372);
    check("clamp_734_b", int'(px_b), 736);
    repeat (9) frame();
    check("right_10_a", int'(px_a), 408);
    check("clamp_736_b", int'(px_b), 736);
    over_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      frame();
      if (px_a > 11'd736) over_cnt++;
    end
    check("right_100_a", int'(px_a), 736);
    check("right_never_over", over_cnt, 0);

    // reset in the middle of the active area
    btn_right = 1'b0;
    vin.vblnk = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("midrst_px_a", int'(px_a), 368);
    check("midrst_px_b", int'(px_b), 734);
    rst = 1'b0;
    step();

    btn_left = 1'b1;
    repeat (92) frame();
    check("left_92_a", int'(px_a), 0);
    check("left_92_b", int'(px_b), 366);
    frame();
    check("left_nowrap_a", int'(px_a), 0);
    check("left_93_b", int'(px_b), 362);
    repeat (90) frame();
    check("left_at2_b", int'(px_b), 2);
    frame();
    check("clamp_2_b", int'(px_b), 0);
    frame();
    check("stay_0_b", int'(px_b), 0);

    btn_left = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    btn_left  = 1'b1;
    btn_right = 1'b1;
    repeat (3) frame();
    check("both_a", int'(px_a), 368);
    check("both_b", int'(px_b), 734);

    // press only between ticks
    btn_left  = 1'b0;
    btn_right = 1'b0;
    vin.vblnk = 1'b0;
    step();
    btn_right = 1'b1;
    repeat (5) step();
    btn_right = 1'b0;
    step();
    vin.vblnk = 1'b1;
    step();
    step();
    check("short_press_a", int'(px_a), 368);
    frame();
    check("neither_a", int'(px_a), 368);

    // pixel overlay with paddle at x=368 (dut_a) and x=734 (dut_b)
    vin.hsync = 1'b0;
    vin.vsync = 1'b0;
    pix(368, 560, 1'b0, 1'b0, 12'h123, EXP_COLOR, "pix_top_left");
    pix(431, 575, 1'b0, 1'b0, 12'h123, EXP_COLOR, "pix_bot_right");
    pix(432, 560, 1'b0, 1'b0, 12'h456, 12'h456,   "pix_right_out");
    pix(367, 560, 1'b0, 1'b0, 12'h789, 12'h789,   "pix_left_out");
    pix(368, 576, 1'b0, 1'b0, 12'h0ab, 12'h0ab,   "pix_below");
    pix(400, 559, 1'b0, 1'b0, 12'h0cd, 12'h0cd,   "pix_above");
    pix(400, 568, 1'b1, 1'b0, 12'h111, 12'h111,   "pix_hblnk");
    pix(400, 568, 1'b0, 1'b1, 12'h222, 12'h222,   "pix_vblnk");
    pix(740, 565, 1'b0, 1'b0, 12'h333, 12'h333,   "pix_a_off");
    check("pix_b_on", int'(vout_b.rgb), int'(EXP_COLOR));
    check("px_a_after_pix", int'(px_a), 368);

    // random pass-through of timing fields
    for (int i = 0; i < 40; i++) begin
      s_hc = 11'($urandom_range(0, 2047));
      s_vc = 11'($urandom_range(0, 2047));
      s_hs = 1'($urandom_range(0, 1));
      s_vs = 1'($urandom_range(0, 1));
      s_hb = 1'($urandom_range(0, 1));
      s_vb = 1'($urandom_range(0, 1));
      vin.hcount = s_hc;
      vin.vcount = s_vc;
      vin.hsync  = s_hs;
      vin.vsync  = s_vs;
      vin.hblnk  = s_hb;
      vin.vblnk  = s_vb;
      vin.rgb    = 12'($urandom_range(0, 4095));
      step();
      check("pt_hcount", int'(vout_a.hcount), int'(s_hc));
      check("pt_vcount", int'(vout_a.vcount), int'(s_vc));
      check("pt_hsync",  int'(vout_a.hsync),  int'(s_hs));
      check("pt_vsync",  int'(vout_a.vsync),  int'(s_vs));
      check("pt_hblnk",  int'(vout_a.hblnk),  int'(s_hb));
      check("pt_vblnk",  int'(vout_a.vblnk),  int'(s_vb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
